// File: rtl/wash_job_scheduler.sv
// wash_job_scheduler: queues paid wash jobs and dispatches them round-robin to idle machines
module wash_job_scheduler #(
  parameter int N_MACH     = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          job_valid,
  input  logic                          job_dw,
  output logic                          job_ready,
  input  logic                          sched_en,
  input  logic [N_MACH-1:0]             mach_avail,
  input  logic [N_MACH-1:0]             mach_done,
  output logic [N_MACH-1:0]             mach_coin,
  output logic [N_MACH-1:0]             mach_dw,
  output logic [N_MACH-1:0]             mach_busy,
  output logic [$clog2(FIFO_DEPTH):0]   q_count,
  output logic                          err_spur
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int PW = $clog2(N_MACH);
  logic [FIFO_DEPTH-1:0] q_dw;
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [PW-1:0]         rr_ptr, g, g_nxt;
  logic [N_MACH-1:0]     idle, g_oh, done_ok;
  logic                  push, disp;
  assign job_ready = q_count != CW'(FIFO_DEPTH);
  assign push      = job_valid && job_ready;
  assign idle      = ~mach_busy & mach_avail;
  assign disp      = sched_en && q_count != '0 && |idle;
  assign g_oh      = disp ? N_MACH'(1) << g : '0;
  assign g_nxt     = g == PW'(N_MACH - 1) ? '0 : g + PW'(1);
  assign done_ok   = mach_done & mach_busy;
  // Round-robin grant: descending scan so the closest idle machine at or after rr_ptr wins
  always_comb begin
    g = '0;
    for (int k = N_MACH - 1; k >= 0; k--)
      if (idle[(int'(rr_ptr) + k) % N_MACH]) g = PW'((int'(rr_ptr) + k) % N_MACH);
  end
  // Job queue storage and pointers; ring wraps naturally at the power-of-two depth
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_dw    <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      q_count <= '0;
    end else begin
      if (push) q_dw[wr_ptr] <= job_dw;
      wr_ptr  <= push ? wr_ptr + AW'(1) : wr_ptr;
      rd_ptr  <= disp ? rd_ptr + AW'(1) : rd_ptr;
      q_count <= q_count + CW'(push) - CW'(disp);
    end
  end
  // Machine ownership: dispatch claims an idle machine, a done pulse on a busy machine frees it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mach_coin <= '0;
      mach_busy <= '0;
      mach_dw   <= '0;
      rr_ptr    <= '0;
      err_spur  <= 1'b0;
    end else begin
      mach_coin <= g_oh;
      mach_busy <= (mach_busy & ~done_ok) | g_oh;
      mach_dw   <= (mach_dw & ~done_ok) | (q_dw[rd_ptr] ? g_oh : '0);
      rr_ptr    <= disp ? g_nxt : rr_ptr;
      err_spur  <= err_spur | |(mach_done & ~mach_busy);
    end
  end
endmodule

// File: tb/tb_wash_job_scheduler.sv
// tb_wash_job_scheduler: directed and random stimulus against a queue-based reference model
module tb_wash_job_scheduler;
  localparam int N = 4;
  localparam int D = 4;
  logic         clk = 1'b0;
  logic         rst, job_valid, job_dw, job_ready, sched_en, err_spur;
  logic [N-1:0] mach_avail, mach_done, mach_coin, mach_dw, mach_busy;
  logic [2:0]   q_count;
  int           n_cmp = 0;
  int           n_bad = 0;
  bit           mq[$];
  logic [N-1:0] m_busy, m_dw, m_coin;
  int           m_rr;
  bit           m_err;

  wash_job_scheduler #(.N_MACH(N), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .job_valid(job_valid), .job_dw(job_dw), .job_ready(job_ready),
    .sched_en(sched_en), .mach_avail(mach_avail), .mach_done(mach_done), .mach_coin(mach_coin),
    .mach_dw(mach_dw), .mach_busy(mach_busy), .q_count(q_count), .err_spur(err_spur)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("coin", 32'(mach_coin), 32'(m_coin));
    chk("dw", 32'(mach_dw), 32'(m_dw));
    chk("busy", 32'(mach_busy), 32'(m_busy));
    chk("q_count", 32'(q_count), 32'(mq.size()));
    chk("job_ready", 32'(job_ready), 32'(mq.size() != D));
    chk("err_spur", 32'(err_spur), 32'(m_err));
  endtask

  task automatic model_reset();
    mq.delete();
    m_busy = '0;
    m_dw = '0;
    m_coin = '0;
    m_rr = 0;
    m_err = 0;
  endtask

  // One clock edge of the scheduler, computed from the pre-edge state
  task automatic model_update();
    int  g;
    bit  push;
    g = -1;
    push = job_valid && mq.size() != D;
    if (sched_en && mq.size() != 0)
      for (int k = 0; k < N; k++)
        if (g < 0 && !m_busy[(m_rr + k) % N] && mach_avail[(m_rr + k) % N]) g = (m_rr + k) % N;
    m_coin = '0;
    for (int i = 0; i < N; i++)
      if (mach_done[i]) begin
        if (m_busy[i]) begin
          m_busy[i] = 1'b0;
          m_dw[i] = 1'b0;
        end else m_err = 1;
      end
    if (g >= 0) begin
      m_busy[g] = 1'b1;
      m_dw[g] = mq.pop_front();
      m_coin[g] = 1'b1;
      m_rr = (g + 1) % N;
    end
    if (push) mq.push_back(job_dw);
  endtask

  task automatic step(input bit v, input bit d, input bit en, input logic [N-1:0] av, input logic [N-1:0] dn);
    job_valid = v;
    job_dw = d;
    sched_en = en;
    mach_avail = av;
    mach_done = dn;
    @(posedge clk);
    model_update();
    @(negedge clk);
    job_valid = 1'b0;
    mach_done = '0;
    check_all();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    job_valid = 1'b0;
    mach_done = '0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    rst = 1'b1;
    check_all();
  endtask

  initial begin
    rst = 1'b0;
    job_valid = 1'b0;
    job_dw = 1'b0;
    sched_en = 1'b0;
    mach_avail = '1;
    mach_done = '0;
    model_reset();
    repeat (2) @(negedge clk);
    do_reset();
    chk("reset_ready", 32'(job_ready), 32'd1);
    // single double-wash job to machine 0
    step(1, 1, 1, 4'b1111, '0);
    chk("single_q1", 32'(q_count), 32'd1);
    step(0, 0, 1, 4'b1111, '0);
    chk("single_coin", 32'(mach_coin), 32'b0001);
    chk("single_dw", 32'(mach_dw), 32'b0001);
    step(0, 0, 1, 4'b1111, '0);
    chk("single_coin_off", 32'(mach_coin), 32'd0);
    step(0, 0, 1, 4'b1111, 4'b0001);
    chk("single_free", 32'(mach_busy), 32'd0);
    // fill queue with dispatch held
    for (int i = 0; i < 5; i++) step(1, i[0], 0, 4'b1111, '0);
    chk("full_q", 32'(q_count), 32'd4);
    chk("full_ready", 32'(job_ready), 32'd0);
    step(1, 1, 1, 4'b1111, '0);
    step(1, 1, 1, 4'b1111, '0);
    repeat (4) step(0, 0, 1, 4'b1111, '0);
    step(0, 0, 1, 4'b1111, m_busy);
    // round-robin with machine 2 out of service
    do_reset();
    for (int i = 0; i < 4; i++) step(1, 0, 1, 4'b1011, '0);
    repeat (3) step(0, 0, 1, 4'b1011, '0);
    chk("rr_busy", 32'(mach_busy), 32'b1011);
    chk("rr_wait", 32'(q_count), 32'd1);
    step(0, 0, 1, 4'b1011, 4'b0010);
    step(0, 0, 1, 4'b1011, '0);
    chk("rr_redisp", 32'(mach_coin), 32'b0010);
    step(0, 0, 1, 4'b1011, 4'b1011);
    // push+pop at q_count=2, order 1,0,1
    step(1, 1, 0, 4'b1111, '0);
    step(1, 0, 0, 4'b1111, '0);
    step(1, 1, 1, 4'b1111, '0);
    chk("pp_q2", 32'(q_count), 32'd2);
    repeat (3) step(0, 0, 1, 4'b1111, '0);
    // spurious done on idle machine 2
    step(0, 0, 1, 4'b1111, m_busy);
    step(0, 0, 1, 4'b1111, 4'b0100);
    chk("spur_set", 32'(err_spur), 32'd1);
    step(0, 0, 1, 4'b1111, '0);
    chk("spur_sticky", 32'(err_spur), 32'd1);
    // reset with 3 queued and 2 busy
    do_reset();
    for (int i = 0; i < 5; i++) step(1, 1, 1, 4'b0011, '0);
    step(0, 0, 1, 4'b0011, '0);
    chk("mid_pre_q", 32'(q_count), 32'd3);
    do_reset();
    chk("mid_q", 32'(q_count), 32'd0);
    chk("mid_busy", 32'(mach_busy), 32'd0);
    step(0, 0, 1, 4'b1111, '0);
    chk("mid_no_replay", 32'(mach_coin), 32'd0);
    // random traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      logic [N-1:0] av, dn;
      av = 4'hF ^ (4'($urandom) & 4'($urandom) & 4'($urandom));
      dn = m_busy & 4'($urandom) & 4'($urandom);
      if ($urandom_range(0, 199) == 0) dn[$urandom_range(0, N - 1)] = 1'b1;
      step(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), $urandom_range(0, 7) != 0, av, dn);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
